// File: rtl/writeback_if.sv
// Upstream result handshake into the writeback stage: one completed result per transfer,
// optionally carrying a second (high) half destined for R0.
interface writeback_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_kind;
    logic [ADDR_W-1:0] in_dest;
    logic [DATA_W-1:0] in_data;
    logic [DATA_W-1:0] in_data_hi;

    modport master (
        output in_valid,
        output in_kind,
        output in_dest,
        output in_data,
        output in_data_hi,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_kind,
        input  in_dest,
        input  in_data,
        input  in_data_hi,
        output in_ready
    );
endinterface

// File: rtl/writeback_sequencer.sv
// Writeback sequencer: buffers completed results, serialises dual-destination results into
// two single register-file writes, and forwards not-yet-retired values to decode.
module writeback_sequencer #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              reset,
    writeback_if.slave        up,
    output logic [ADDR_W-1:0] write_reg,
    output logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] r0,
    output logic [1:0]        reg_write,
    input  logic [ADDR_W-1:0] query_reg1,
    input  logic [ADDR_W-1:0] query_reg2,
    output logic              fwd_hit1,
    output logic              fwd_hit2,
    output logic [DATA_W-1:0] fwd_data1,
    output logic [DATA_W-1:0] fwd_data2,
    output logic              busy
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [1:0] KIND_NONE = 2'b00;
    localparam logic [1:0] KIND_RD   = 2'b01;
    localparam logic [1:0] KIND_R0   = 2'b10;
    localparam logic [1:0] KIND_BOTH = 2'b11;

    localparam logic [1:0] RW_IDLE = 2'b00;
    localparam logic [1:0] RW_R0   = 2'b01;
    localparam logic [1:0] RW_RD   = 2'b11;

    typedef enum logic {
        ST_LO = 1'b0,
        ST_HI = 1'b1
    } phase_t;

    typedef struct packed {
        logic [1:0]        kind;
        logic [ADDR_W-1:0] dest;
        logic [DATA_W-1:0] data;
        logic [DATA_W-1:0] data_hi;
    } entry_t;

    entry_t             fifo_mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_reg, rd_ptr_next;
    logic [PTR_W-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [CNT_W-1:0]   count_reg, count_next;
    phase_t             state_reg, state_next;

    logic [1:0]         reg_write_reg, reg_write_next;
    logic [ADDR_W-1:0]  write_reg_reg, write_reg_next;
    logic [DATA_W-1:0]  write_data_reg, write_data_next;
    logic [DATA_W-1:0]  r0_reg, r0_next;

    logic               in_ready_int;
    logic               push;
    logic               pop;
    entry_t             entry_in;
    entry_t             head;

    // ------------------------------------------------------------------
    // Acceptance: kind 00 completes the handshake but never occupies a slot.
    // ------------------------------------------------------------------
    assign in_ready_int = reset && (count_reg < CNT_W'(DEPTH));
    assign up.in_ready  = in_ready_int;
    assign push         = up.in_valid && in_ready_int && (up.in_kind != KIND_NONE);

    assign entry_in.kind    = up.in_kind;
    assign entry_in.dest    = up.in_dest;
    assign entry_in.data    = up.in_data;
    assign entry_in.data_hi = up.in_data_hi;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= entry_in;
        end
    end

    assign head = fifo_mem[rd_ptr_reg];

    // ------------------------------------------------------------------
    // Sequencer: next-state and next-output decode from the FIFO head.
    // ------------------------------------------------------------------
    always_comb begin
        state_next      = state_reg;
        reg_write_next  = RW_IDLE;
        write_reg_next  = write_reg_reg;
        write_data_next = write_data_reg;
        r0_next         = r0_reg;
        pop             = 1'b0;

        if (count_reg != '0) begin
            case (state_reg)
                ST_LO: begin
                    case (head.kind)
                        KIND_RD: begin
                            reg_write_next  = RW_RD;
                            write_reg_next  = head.dest;
                            write_data_next = head.data;
                            pop             = 1'b1;
                        end
                        KIND_R0: begin
                            reg_write_next = RW_R0;
                            r0_next        = head.data;
                            pop            = 1'b1;
                        end
                        KIND_BOTH: begin
                            // Low half now; the entry stays at the head for its R0 half.
                            reg_write_next  = RW_RD;
                            write_reg_next  = head.dest;
                            write_data_next = head.data;
                            state_next      = ST_HI;
                        end
                        default: begin
                            pop = 1'b1;
                        end
                    endcase
                end
                ST_HI: begin
                    reg_write_next = RW_R0;
                    r0_next        = head.data_hi;
                    pop            = 1'b1;
                    state_next     = ST_LO;
                end
                default: begin
                    state_next = ST_LO;
                end
            endcase
        end
    end

    always_comb begin
        wr_ptr_next = wr_ptr_reg + PTR_W'(push);
        rd_ptr_next = rd_ptr_reg + PTR_W'(pop);
        count_next  = count_reg + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg      <= ST_LO;
            rd_ptr_reg     <= '0;
            wr_ptr_reg     <= '0;
            count_reg      <= '0;
            reg_write_reg  <= RW_IDLE;
            write_reg_reg  <= '0;
            write_data_reg <= '0;
            r0_reg         <= '0;
        end else begin
            state_reg      <= state_next;
            rd_ptr_reg     <= rd_ptr_next;
            wr_ptr_reg     <= wr_ptr_next;
            count_reg      <= count_next;
            reg_write_reg  <= reg_write_next;
            write_reg_reg  <= write_reg_next;
            write_data_reg <= write_data_next;
            r0_reg         <= r0_next;
        end
    end

    assign reg_write  = reg_write_reg;
    assign write_reg  = write_reg_reg;
    assign write_data = write_data_reg;
    assign r0         = r0_reg;
    assign busy       = (count_reg != '0) || (state_reg == ST_HI);

    // ------------------------------------------------------------------
    // Forwarding: scan pending entries oldest to youngest so the youngest
    // match overwrites; within one entry the R0 half is checked last.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            logic [ADDR_W-1:0] query;
            logic              hit;
            logic [DATA_W-1:0] data;

            assign query = (gi == 0) ? query_reg1 : query_reg2;

            always_comb begin
                entry_t           e;
                logic [PTR_W-1:0] idx;
                logic             lo_ok;
                hit   = 1'b0;
                data  = '0;
                e     = '0;
                idx   = '0;
                lo_ok = 1'b0;
                for (int i = 0; i < DEPTH; i++) begin
                    idx   = rd_ptr_reg + PTR_W'(i);
                    e     = fifo_mem[idx];
                    // The head's low half has already retired once the HI phase starts.
                    lo_ok = (i != 0) || (state_reg == ST_LO);
                    if (CNT_W'(i) < count_reg) begin
                        if (lo_ok && ((e.kind == KIND_RD) || (e.kind == KIND_BOTH))
                            && (e.dest == query)) begin
                            hit  = 1'b1;
                            data = e.data;
                        end
                        if ((query == '0) && ((e.kind == KIND_R0) || (e.kind == KIND_BOTH))) begin
                            hit  = 1'b1;
                            data = (e.kind == KIND_BOTH) ? e.data_hi : e.data;
                        end
                    end
                end
            end
        end
    endgenerate

    assign fwd_hit1  = g_fwd[0].hit;
    assign fwd_data1 = g_fwd[0].data;
    assign fwd_hit2  = g_fwd[1].hit;
    assign fwd_data2 = g_fwd[1].data;

endmodule

// File: tb/tb_writeback_sequencer.sv
// Directed bench for writeback_sequencer: the stimulus pushes expected register-file writes
// into a queue and a negedge monitor pops and compares every write the DUT presents.
module tb_writeback_sequencer;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 2;

    logic              clk;
    logic              reset;
    logic [ADDR_W-1:0] write_reg;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] r0;
    logic [1:0]        reg_write;
    logic [ADDR_W-1:0] query_reg1, query_reg2;
    logic              fwd_hit1, fwd_hit2;
    logic [DATA_W-1:0] fwd_data1, fwd_data2;
    logic              busy;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [1:0]  rw;
        logic [3:0]  wreg;
        logic [15:0] data;
    } exp_t;

    exp_t exp_q[$];

    writeback_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) up_if ();

    writeback_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .up         (up_if),
        .write_reg  (write_reg),
        .write_data (write_data),
        .r0         (r0),
        .reg_write  (reg_write),
        .query_reg1 (query_reg1),
        .query_reg2 (query_reg2),
        .fwd_hit1   (fwd_hit1),
        .fwd_hit2   (fwd_hit2),
        .fwd_data1  (fwd_data1),
        .fwd_data2  (fwd_data2),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Offer one result, wait (bounded) for acceptance, and record the writes it must produce.
    task automatic send(input logic [1:0] k, input logic [3:0] d,
                        input logic [15:0] lo, input logic [15:0] hi);
        int waited = 0;
        up_if.in_valid   = 1'b1;
        up_if.in_kind    = k;
        up_if.in_dest    = d;
        up_if.in_data    = lo;
        up_if.in_data_hi = hi;
        while (!up_if.in_ready && waited < 20) begin
            cycle();
            waited++;
        end
        if (!up_if.in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready stayed 0 for kind %b dest %0d", k, d);
            up_if.in_valid = 1'b0;
            return;
        end
        cycle();
        case (k)
            2'b01: exp_q.push_back('{rw: 2'b11, wreg: d, data: lo});
            2'b10: exp_q.push_back('{rw: 2'b01, wreg: 4'd0, data: lo});
            2'b11: begin
                exp_q.push_back('{rw: 2'b11, wreg: d, data: lo});
                exp_q.push_back('{rw: 2'b01, wreg: 4'd0, data: hi});
            end
            default: ;
        endcase
        up_if.in_valid = 1'b0;
        $display("send: kind=%b dest=%0d data=0x%h hi=0x%h", k, d, lo, hi);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 30) begin
            cycle();
            n++;
        end
        chk(name, {31'd0, (exp_q.size() == 0 && !busy)}, 32'd1);
    endtask

    // Monitor: every presented write must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reset && reg_write != 2'b00) begin
            $display("write: reg_write=%b write_reg=%0d write_data=0x%h r0=0x%h",
                     reg_write, write_reg, write_data, r0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got reg_write=%b required none", reg_write);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("mon_reg_write", {30'd0, reg_write}, {30'd0, e.rw});
                if (e.rw == 2'b11) begin
                    chk("mon_write_reg", {28'd0, write_reg}, {28'd0, e.wreg});
                    chk("mon_write_data", {16'd0, write_data}, {16'd0, e.data});
                end else begin
                    chk("mon_r0", {16'd0, r0}, {16'd0, e.data});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset            = 1'b0;
        up_if.in_valid   = 1'b0;
        up_if.in_kind    = 2'b00;
        up_if.in_dest    = '0;
        up_if.in_data    = '0;
        up_if.in_data_hi = '0;
        query_reg1       = '0;
        query_reg2       = '0;

        // Reset
        cycle();
        chk("ready_in_reset", {31'd0, up_if.in_ready}, 32'd0);
        cycle();
        reset = 1'b1;
        #1;
        chk("rst_reg_write", {30'd0, reg_write}, 32'd0);
        chk("rst_in_ready", {31'd0, up_if.in_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_write_reg", {28'd0, write_reg}, 32'd0);
        chk("rst_write_data", {16'd0, write_data}, 32'd0);
        chk("rst_r0", {16'd0, r0}, 32'd0);
        for (int q = 0; q < 16; q++) begin
            query_reg1 = 4'(q);
            #1;
            chk("rst_fwd_hit1", {31'd0, fwd_hit1}, 32'd0);
        end

        // Kind 01: one-cycle latency, then idle
        query_reg1 = 4'd5;
        send(2'b01, 4'd5, 16'h1234, 16'h0000);
        chk("k01_fwd_hit", {31'd0, fwd_hit1}, 32'd1);
        chk("k01_fwd_data", {16'd0, fwd_data1}, 32'h1234);
        chk("k01_busy", {31'd0, busy}, 32'd1);
        cycle();
        chk("k01_reg_write", {30'd0, reg_write}, 32'h3);
        chk("k01_write_reg", {28'd0, write_reg}, 32'd5);
        chk("k01_write_data", {16'd0, write_data}, 32'h1234);
        cycle();
        chk("k01_idle", {30'd0, reg_write}, 32'd0);
        chk("k01_not_busy", {31'd0, busy}, 32'd0);

        // Kind 10: R0 only; Rd outputs hold
        send(2'b10, 4'd9, 16'h7777, 16'h0000);
        cycle();
        chk("k10_reg_write", {30'd0, reg_write}, 32'h1);
        chk("k10_r0", {16'd0, r0}, 32'h7777);
        chk("k10_hold_reg", {28'd0, write_reg}, 32'd5);
        chk("k10_hold_data", {16'd0, write_data}, 32'h1234);

        // Kind 00: handshake only
        cycle();
        send(2'b00, 4'd6, 16'hDEAD, 16'hBEEF);
        chk("k00_not_busy", {31'd0, busy}, 32'd0);
        cycle();
        chk("k00_no_write", {30'd0, reg_write}, 32'd0);

        // Kind 11: Rd then R0, with forwarding of both halves
        query_reg1 = 4'd0;
        query_reg2 = 4'd3;
        send(2'b11, 4'd3, 16'hBEEF, 16'h00FF);
        chk("k11_fwd1_hit", {31'd0, fwd_hit1}, 32'd1);
        chk("k11_fwd1_data", {16'd0, fwd_data1}, 32'h00FF);
        chk("k11_fwd2_data", {16'd0, fwd_data2}, 32'hBEEF);
        cycle();
        chk("k11_c1_reg_write", {30'd0, reg_write}, 32'h3);
        chk("k11_c1_write_reg", {28'd0, write_reg}, 32'd3);
        chk("k11_c1_write_data", {16'd0, write_data}, 32'hBEEF);
        chk("k11_c1_fwd1_hit", {31'd0, fwd_hit1}, 32'd1);
        chk("k11_c1_fwd1_data", {16'd0, fwd_data1}, 32'h00FF);
        chk("k11_c1_fwd2_hit", {31'd0, fwd_hit2}, 32'd0);
        chk("k11_c1_busy", {31'd0, busy}, 32'd1);
        cycle();
        chk("k11_c2_reg_write", {30'd0, reg_write}, 32'h1);
        chk("k11_c2_r0", {16'd0, r0}, 32'h00FF);
        chk("k11_c2_fwd1_hit", {31'd0, fwd_hit1}, 32'd0);
        chk("k11_c2_fwd1_data", {16'd0, fwd_data1}, 32'd0);
        chk("k11_c2_busy", {31'd0, busy}, 32'd0);

        // Back-pressure: kind 11 head stalls the FIFO, ordering preserved
        send(2'b11, 4'd1, 16'h0101, 16'h0F0F);
        send(2'b01, 4'd2, 16'h0202, 16'h0000);
        chk("full_in_ready", {31'd0, up_if.in_ready}, 32'd0);
        chk("full_busy", {31'd0, busy}, 32'd1);
        send(2'b01, 4'd3, 16'h0303, 16'h0000);
        wait_drain("bp_drain");

        // Kind 11 with dest 0: R0 written twice, high half last
        query_reg1 = 4'd0;
        send(2'b11, 4'd0, 16'h1111, 16'h2222);
        chk("d0_fwd_data", {16'd0, fwd_data1}, 32'h2222);
        wait_drain("d0_drain");
        chk("d0_final_r0", {16'd0, r0}, 32'h2222);
        chk("d0_write_data", {16'd0, write_data}, 32'h1111);

        // Youngest wins: R0 half of an older kind 11 vs a younger kind 10
        query_reg1 = 4'd9;
        query_reg2 = 4'd0;
        send(2'b11, 4'd9, 16'h9999, 16'hAAAA);
        send(2'b10, 4'd0, 16'h5555, 16'h0000);
        chk("yw_fwd2_hit", {31'd0, fwd_hit2}, 32'd1);
        chk("yw_fwd2_data", {16'd0, fwd_data2}, 32'h5555);
        chk("yw_lo_retired", {31'd0, fwd_hit1}, 32'd0);
        cycle();
        chk("yw_fwd2_data_hi", {16'd0, fwd_data2}, 32'h5555);
        cycle();
        chk("yw_retired_hit", {31'd0, fwd_hit2}, 32'd0);
        chk("yw_retired_data", {16'd0, fwd_data2}, 32'd0);
        wait_drain("yw_drain");

        // Reset during the HI phase: R0 half abandoned
        query_reg1 = 4'd0;
        send(2'b11, 4'd6, 16'h6666, 16'h7777);
        cycle();
        chk("mid_lo_reg_write", {30'd0, reg_write}, 32'h3);
        reset = 1'b0;
        cycle();
        exp_q.delete();
        chk("mid_reg_write", {30'd0, reg_write}, 32'd0);
        chk("mid_r0", {16'd0, r0}, 32'd0);
        chk("mid_write_reg", {28'd0, write_reg}, 32'd0);
        chk("mid_write_data", {16'd0, write_data}, 32'd0);
        chk("mid_busy", {31'd0, busy}, 32'd0);
        chk("mid_ready_low", {31'd0, up_if.in_ready}, 32'd0);
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            cycle();
            chk("post_rst_idle", {30'd0, reg_write}, 32'd0);
        end
        chk("post_rst_busy", {31'd0, busy}, 32'd0);
        chk("post_rst_fwd", {31'd0, fwd_hit1}, 32'd0);
        chk("post_rst_ready", {31'd0, up_if.in_ready}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/writeback_sequencer.md
Name: writeback_sequencer

Overview:
- Writeback-stage block that drives the register file's write interface: `write_reg`, `write_data`, `r0`, `reg_write`.
- Accepts completed results from the execute/memory stage through a valid/ready handshake and buffers them in a small FIFO.
- Splits dual-destination results (multiply/divide: low half to Rd, high half to R0) into two consecutive single writes, because the register file takes one write per cycle.
- Provides forwarding of pending (not yet written) results to the decode stage.

Parameters:
- DATA_W, 16, register data width
- ADDR_W, 4, register address width
- DEPTH, 2, pending-result FIFO entries (power of 2, at least 2)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  reset, synchronous, active-low
- in_valid  in  1  upstream result valid
- in_ready  out  1  block can accept a result this cycle
- in_kind  in  2  00 no write (dropped); 01 Rd only; 10 R0 only (uses in_data); 11 Rd=in_data then R0=in_data_hi
- in_dest  in  ADDR_W  destination register Rd
- in_data  in  DATA_W  primary/low result
- in_data_hi  in  DATA_W  high result (kind 11 only)
- write_reg  out  ADDR_W  register file write address
- write_data  out  DATA_W  register file write data
- r0  out  DATA_W  register file R0 data
- reg_write  out  2  11 = write `write_reg`; 01 = write R0; 00 = idle
- query_reg1, query_reg2  in  ADDR_W  decode-stage source registers
- fwd_hit1, fwd_hit2  out  1  a pending entry will write the queried register
- fwd_data1, fwd_data2  out  DATA_W  value of that pending write (0 when no hit)
- busy  out  1  FIFO non-empty or a write in progress

Behaviour:
- **Reset** (reset==0 at an edge):
  - FIFO emptied, phase = LO.
  - `reg_write`=00, `write_reg`=0, `write_data`=0, `r0`=0.
  - `in_ready`=0 while reset is low.
- **Accept:**
  - `in_ready` = reset && (count < DEPTH). Pop and push in the same cycle are not combined.
  - A transfer occurs when `in_valid` && `in_ready` at the edge.
  - kind 00 completes the handshake but is not enqueued.
  - Other kinds are enqueued as {kind, dest, data, data_hi}.
- **Output registers** are updated every edge from the FIFO head (sequencer FSM, states LO/HI):
  - Head empty: `reg_write` <= 00. `write_reg`, `write_data` and `r0` hold.
  - LO, kind 01: `reg_write` <= 11, `write_reg` <= dest, `write_data` <= data; pop.
  - LO, kind 10: `reg_write` <= 01, `r0` <= data; pop.
  - LO, kind 11: `reg_write` <= 11, `write_reg` <= dest, `write_data` <= data; phase -> HI; no pop.
  - HI: `reg_write` <= 01, `r0` <= data_hi; pop; phase -> LO.
- **Latency and throughput:**
  - A result accepted at edge N into an empty FIFO appears on the outputs after edge N+1.
  - Kind 11 occupies two output cycles (N+1 and N+2).
  - Sustained throughput is one write per cycle.
- **Ordering:** writes leave in acceptance order. When kind 11 has dest=0, R0 is written twice and data_hi is the final value.
- **Retirement:** an entry's part is retired once it has been loaded into the output registers. The register file sees a presented write in the same cycle.
- **Forwarding** (combinational over FIFO entries not yet retired, including the unretired HI part of the head):
  - An entry matches query q if (kind ∈ {01,11} and dest==q, giving data) or (kind ∈ {10,11} and q==0, giving data for kind 10, data_hi for kind 11).
  - For the head in phase HI, only the R0 part is eligible.
  - If several entries match, the youngest wins. Within a kind 11 entry with dest=0, data_hi wins.
  - No match: hit=0, data=0.
- **busy** = count != 0 or phase==HI.
- **Reset mid-operation:**
  - Pending entries are discarded and the HI phase is abandoned.
  - Outputs return to their reset values at that edge.
  - No partial write is issued after reset.
- Upstream must hold all inputs stable while `in_valid` && !`in_ready`.

Test Plan:
- Reset low 2 cycles, then high → `reg_write`=00, `in_ready`=1, `busy`=0, all data outputs 0, `fwd_hit1`=0 for every `query_reg1`.
- Accept kind 01, dest 5, data 0x1234 at edge N → after N+1: `reg_write`=11, `write_reg`=5, `write_data`=0x1234. After N+2: `reg_write`=00, `busy`=0.
- Accept kind 11, dest 3, data 0xBEEF, hi 0x00FF → cycle 1: `reg_write`=11, `write_reg`=3, `write_data`=0xBEEF. Cycle 2: `reg_write`=01, `r0`=0x00FF. `query_reg1`=0 shows hit with 0x00FF until cycle 2.
- Push 3 back-to-back kind 01 results (dests 1, 2, 3) with DEPTH=2 while the first is kind 11 → `in_ready`=0 when count=2. Writes emerge in order 1(lo), R0(hi), 2, 3, with no loss.
- Two pending entries both to R7 (0xAAAA older, 0x5555 younger), `query_reg2`=7 → `fwd_hit2`=1, `fwd_data2`=0x5555. Once both retire, `fwd_hit2`=0.
- Assert reset during the HI phase of a kind 11 result → the next cycle shows `reg_write`=00 and `r0`=0, the FIFO is empty, and no R0 write follows.
